// File: rtl/cskipa_arbiter.sv
// cskipa_arbiter: round-robin arbiter feeding a two-stage pipeline that
// shares one 16-bit carry-skip adder among NREQ requesters. The result port
// carries the 17-bit sum and the index of the requester that produced it.

// CSkipA_16b: 16-bit carry-skip adder built from four 4-bit ripple blocks.
module CSkipA_16b (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [16:0] sum_o
);

    logic [15:0] sumBits;
    logic        carry;
    logic        blockIn;
    logic        blockProp;
    logic        bitProp;

    // Ripple inside each block; when every bit of a block propagates, the
    // block's incoming carry skips straight to its output.
    always_comb begin
        sumBits   = '0;
        carry     = 1'b0;
        blockIn   = 1'b0;
        blockProp = 1'b0;
        bitProp   = 1'b0;
        for (int blk = 0; blk < 4; blk++) begin
            blockIn   = carry;
            blockProp = 1'b1;
            for (int k = 0; k < 4; k++) begin
                bitProp              = a_i[4*blk+k] ^ b_i[4*blk+k];
                sumBits[4*blk+k]     = bitProp ^ carry;
                carry                = (a_i[4*blk+k] & b_i[4*blk+k]) | (bitProp & carry);
                blockProp            = blockProp & bitProp;
            end
            if (blockProp) begin
                carry = blockIn;
            end
        end
        sum_o = {carry, sumBits};
    end

endmodule

module cskipa_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [16*NREQ-1:0]   req_a_i,
    input  logic [16*NREQ-1:0]   req_b_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [16:0]          res_sum_o,
    output logic [IDW-1:0]       res_id_o
);

    // Round-robin pointer: index searched first in the next arbitration
    logic [IDW-1:0] rrPtr_q, rrPtr_d;

    // Stage 1: registered operands of the granted requester
    logic           s1Valid_q, s1Valid_d;
    logic [15:0]    s1A_q, s1A_d;
    logic [15:0]    s1B_q, s1B_d;
    logic [IDW-1:0] s1Id_q, s1Id_d;

    // Stage 2: registered result presented on the output port
    logic           resValid_q;
    logic [16:0]    resSum_q;
    logic [IDW-1:0] resId_q;

    logic           s2Load;
    logic           s1Load;
    logic           grantValid;
    logic [IDW-1:0] grantIdx;
    int             cand;
    logic [16:0]    adderSum;

    assign s2Load = ~resValid_q | res_ready_i;
    assign s1Load = ~s1Valid_q | s2Load;

    // Pick the first requester at or above rrPtr_q (wrapping); no grant when
    // stage 1 cannot accept or while reset is held.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        cand       = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rrPtr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!grantValid && req_valid_i[cand]) begin
                grantValid = 1'b1;
                grantIdx   = IDW'(cand);
            end
        end
        grantValid  = grantValid & s1Load & rst_n;
        req_ready_o = grantValid ? (NREQ'(1) << grantIdx) : '0;
    end

    // Next-state for the pointer and stage 1, driven by the grant decision
    always_comb begin
        rrPtr_d   = rrPtr_q;
        s1Valid_d = s1Valid_q;
        s1A_d     = s1A_q;
        s1B_d     = s1B_q;
        s1Id_d    = s1Id_q;
        if (s1Load) begin
            s1Valid_d = grantValid;
        end
        if (grantValid) begin
            s1A_d  = req_a_i[16*int'(grantIdx) +: 16];
            s1B_d  = req_b_i[16*int'(grantIdx) +: 16];
            s1Id_d = grantIdx;
            if (int'(grantIdx) == NREQ - 1) begin
                rrPtr_d = '0;
            end else begin
                rrPtr_d = grantIdx + IDW'(1);
            end
        end
    end

    // Register the pointer and stage 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr_q   <= '0;
            s1Valid_q <= 1'b0;
            s1A_q     <= '0;
            s1B_q     <= '0;
            s1Id_q    <= '0;
        end else begin
            rrPtr_q   <= rrPtr_d;
            s1Valid_q <= s1Valid_d;
            s1A_q     <= s1A_d;
            s1B_q     <= s1B_d;
            s1Id_q    <= s1Id_d;
        end
    end

    CSkipA_16b u_adder (
        .a_i   (s1A_q),
        .b_i   (s1B_q),
        .sum_o (adderSum)
    );

    // Stage 2 takes the adder output whenever it is free or being drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resValid_q <= 1'b0;
            resSum_q   <= '0;
            resId_q    <= '0;
        end else if (s2Load) begin
            resValid_q <= s1Valid_q;
            if (s1Valid_q) begin
                resSum_q <= adderSum;
                resId_q  <= s1Id_q;
            end
        end
    end

    assign res_valid_o = resValid_q;
    assign res_sum_o   = resSum_q;
    assign res_id_o    = resId_q;

endmodule

// File: tb/tb_cskipa_arbiter.sv
// tb_cskipa_arbiter: scoreboard bench for cskipa_arbiter. The model tracks
// in-flight operations as a queue with ages and decides grants from the
// round-robin rule; a separate monitor compares results against the queue.
module tb_cskipa_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     reqValid;
    logic [NREQ-1:0]     reqReady;
    logic [16*NREQ-1:0]  reqA;
    logic [16*NREQ-1:0]  reqB;
    logic                resValid;
    logic                resReady;
    logic [16:0]         resSum;
    logic [IDW-1:0]      resId;

    logic [15:0] aVal [NREQ];
    logic [15:0] bVal [NREQ];

    typedef struct {
        logic [IDW-1:0] id;
        logic [16:0]    sum;
        int             age;
    } op_t;

    op_t sb[$];
    int  rrNext = 0;
    int  total  = 0;
    int  bad    = 0;

    cskipa_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (reqValid),
        .req_ready_o (reqReady),
        .req_a_i     (reqA),
        .req_b_i     (reqB),
        .res_valid_o (resValid),
        .res_ready_i (resReady),
        .res_sum_o   (resSum),
        .res_id_o    (resId)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Pack per-requester operands onto the wide buses
    always_comb begin
        reqA = '0;
        reqB = '0;
        for (int i = 0; i < NREQ; i++) begin
            reqA[16*i +: 16] = aVal[i];
            reqB[16*i +: 16] = bVal[i];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic ready, input int cycles);
        reqValid = valid;
        resReady = ready;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        sb.delete();
        rrNext = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Model: decide the expected grant, check req_ready, record accepted ops
    always begin : model
        int g;
        int c;
        logic [NREQ-1:0] expReady;
        @(negedge clk);
        #1;
        if (!rst_n) begin
            checkOutput("req_ready in reset", reqReady, 0);
        end else begin
            g = -1;
            if (sb.size() < 2) begin
                for (int k = 0; k < NREQ; k++) begin
                    c = (rrNext + k) % NREQ;
                    if (g < 0 && reqValid[c]) g = c;
                end
            end
            expReady = (g >= 0) ? (NREQ'(1) << g) : '0;
            checkOutput("req_ready", reqReady, expReady);
            foreach (sb[i]) sb[i].age++;
            if (g >= 0) begin
                sb.push_back('{id: IDW'(g), sum: 17'(aVal[g]) + 17'(bVal[g]), age: 0});
                rrNext = (g + 1) % NREQ;
            end
        end
    end

    // Monitor: compare the result port against the oldest outstanding op
    always @(negedge clk) begin : monitor
        logic expValid;
        if (!rst_n) begin
            checkOutput("res_valid in reset", resValid, 0);
        end else begin
            expValid = (sb.size() > 0) && (sb[0].age >= 1);
            checkOutput("res_valid", resValid, expValid);
            if (expValid) begin
                checkOutput("res_sum", resSum, sb[0].sum);
                checkOutput("res_id", resId, sb[0].id);
                if (resReady) void'(sb.pop_front());
            end
        end
    end

    initial begin
        int budget;
        rst_n    = 1'b0;
        reqValid = '1;
        resReady = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            aVal[i] = '0;
            bVal[i] = '0;
        end

        // Reset state
        #2;
        checkOutput("reset req_ready", reqReady, 0);
        checkOutput("reset res_valid", resValid, 0);
        checkOutput("reset res_sum", resSum, 0);
        checkOutput("reset res_id", resId, 0);
        reqValid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single operations from requester 2
        aVal[2] = 16'hFFFF; bVal[2] = 16'h0001;
        applyStimulus(4'b0100, 1'b1, 1);
        applyStimulus(4'b0000, 1'b1, 3);
        aVal[2] = 16'h1234; bVal[2] = 16'h4321;
        applyStimulus(4'b0100, 1'b1, 1);
        applyStimulus(4'b0000, 1'b1, 3);

        // Contention from reset
        pulseReset();
        for (int i = 0; i < NREQ; i++) begin
            aVal[i] = 16'(16'h1000 * (i + 1));
            bVal[i] = 16'(i + 7);
        end
        applyStimulus(4'b1111, 1'b1, 9);
        applyStimulus(4'b0000, 1'b1, 3);

        // Priority wrap: grant 2 leaves the pointer at 3
        applyStimulus(4'b0100, 1'b1, 1);
        applyStimulus(4'b1001, 1'b1, 2);
        applyStimulus(4'b0000, 1'b1, 3);

        // Backpressure then drain
        aVal[1] = 16'hABCD; bVal[1] = 16'h1111;
        applyStimulus(4'b0010, 1'b0, 5);
        applyStimulus(4'b0000, 1'b1, 4);

        // Carry extremes
        aVal[0] = 16'h0000; bVal[0] = 16'h0000;
        applyStimulus(4'b0001, 1'b1, 1);
        aVal[0] = 16'hFFFF; bVal[0] = 16'hFFFF;
        applyStimulus(4'b0001, 1'b1, 1);
        aVal[0] = 16'h8000; bVal[0] = 16'h8000;
        applyStimulus(4'b0001, 1'b1, 1);
        applyStimulus(4'b0000, 1'b1, 3);

        // Random traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                aVal[i] = 16'($urandom);
                bVal[i] = 16'($urandom);
                if ($urandom_range(0, 7) == 0) aVal[i] = 16'hFFFF;
            end
            applyStimulus(NREQ'($urandom), ($urandom_range(0, 3) != 0), 1);
        end
        applyStimulus(4'b0000, 1'b1, 4);

        // Reset mid-operation with both stages full
        applyStimulus(4'b1111, 1'b0, 3);
        #1;
        rst_n = 1'b0;
        sb.delete();
        rrNext = 0;
        #1;
        checkOutput("async reset res_valid", resValid, 0);
        checkOutput("async reset req_ready", reqReady, 0);
        checkOutput("async reset res_sum", resSum, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(4'b1111, 1'b1, 4);

        // Drain with a bounded wait
        reqValid = '0;
        resReady = 1'b1;
        budget = 0;
        while (sb.size() > 0 && budget < 20) begin
            @(posedge clk);
            #1;
            budget++;
        end
        checkOutput("scoreboard drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
